// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family.
package fifo_pkg;

  // Default geometry.
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  // Pointers carry one extra wrap bit above the address.
  localparam int unsigned DEF_PTR_WIDTH = DEF_ADDR_WIDTH + 1;

  // Read-mode encodings for the FWFT parameter.
  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // Pointer width for an arbitrary address width.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array: synchronous write port, asynchronous read port, no reset.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Write the addressed word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with selectable FWFT read, almost flags, occupancy count
// and sticky overflow/underflow flags.
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned FWFT          = MODE_STD,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  input  logic                  ren,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PtrWidth = ptr_width(ADDR_WIDTH);
  localparam bit          IsFwft   = (FWFT == MODE_FWFT);

  // Thresholds fit in the pointer width because they never exceed DEPTH.
  localparam logic [PtrWidth-1:0] AfullTh  = PtrWidth'(AFULL_THRESH);
  localparam logic [PtrWidth-1:0] AemptyTh = PtrWidth'(AEMPTY_THRESH);

  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [PtrWidth-1:0]   count_w;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  empty, full;
  logic                  wr_acc, rd_acc;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status decode straight from the pointer registers.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PtrWidth-1] != rptr_q[PtrWidth-1]) &&
              (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    count_w = wptr_q - rptr_q;
    waddr   = wptr_q[ADDR_WIDTH-1:0];
    raddr   = rptr_q[ADDR_WIDTH-1:0];
  end

  // Accepts use pre-edge full/empty, so wen&ren on a full FIFO drops the
  // write and on an empty FIFO drops the read.
  always_comb begin
    wr_acc = wen & ~full;
    rd_acc = ren & ~empty;
    wptr_d = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_acc ? rptr_q + 1'b1 : rptr_q;
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (wen & full);
    udf_d = (udf_q & ~clr_err) | (ren & empty);
  end

  // Pointer and error-flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // Read data path: registered pop or fall-through of the head word.
  if (!IsFwft) begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;

    // Capture the head word on an accepted read; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_fwft
    // Head word is visible as soon as the FIFO is non-empty.
    assign rdata = empty ? '0 : mem_rdata;
  end

  // Output flags.
  always_comb begin
    wfull         = full;
    rempty        = empty;
    count         = count_w;
    walmost_full  = (count_w >= AfullTh);
    ralmost_empty = (count_w <= AemptyTh);
    overflow      = ovf_q;
    underflow     = udf_q;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
Single-clock, parametrised synchronous FIFO for same-domain buffering where the dual-clock FIFO's Gray-code synchronisers add latency for no benefit. It adds features the dual-clock FIFO lacks:
- selectable first-word-fall-through (FWFT) read mode
- programmable almost-full / almost-empty flags
- occupancy count
- sticky overflow / underflow error flags

Parameters:
DATA_WIDTH, 8, width of each data word
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (legal: ADDR_WIDTH >= 1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, 6, walmost_full asserts when count >= value (legal: 1..DEPTH)
AEMPTY_THRESH, 1, ralmost_empty asserts when count <= value (legal: 0..DEPTH-1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
wdata  input  DATA_WIDTH  write data
wen  input  1  write request
ren  input  1  read request
clr_err  input  1  single-cycle pulse; clears overflow and underflow
rdata  output  DATA_WIDTH  read data
wfull  output  1  FIFO full
rempty  output  1  FIFO empty
walmost_full  output  1  count >= AFULL_THRESH
ralmost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: wptr=0, rptr=0, rdata=0, overflow=0, underflow=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1. Memory contents are not reset.
- Reset mid-operation discards all contents; the first edge after release behaves as an empty FIFO.
- Pointers: wptr and rptr are ADDR_WIDTH+1-bit binary. Address = low ADDR_WIDTH bits; MSB is the wrap bit.
- Flag decode (combinational from pointer registers, no extra latency):
  - empty: wptr == rptr
  - full: MSBs differ and low bits equal
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1)
- Write accept = wen & !wfull. On accept: mem[waddr] <= wdata; wptr += 1.
- Read accept = ren & !rempty. On accept: rptr += 1.
- Full and empty are evaluated on pre-edge state:
  - wen & ren when full: read accepted, write rejected; overflow set.
  - wen & ren when empty: write accepted, read rejected; underflow set.
  - wen & ren otherwise: both accepted, count unchanged.
- FWFT=0: rdata is registered and loads mem[raddr] on the edge of an accepted read (1-cycle latency). It holds its value otherwise, including on rejected reads.
- FWFT=1: rdata = mem[raddr] combinationally whenever rempty=0; it is 0 when empty.
  - The first word appears and rempty falls one cycle after the accepting write edge.
  - After an accepted read, the next word is presented in the following cycle.
- Error flags: overflow <= 1 on (wen & wfull); underflow <= 1 on (ren & rempty).
  - Both flags hold until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, set wins.
- Wrap-around: pointers roll over naturally after 2**(ADDR_WIDTH+1) operations. Flags stay correct indefinitely.

Decomposition:
- Shared package fifo_pkg:
  - default DATA_WIDTH and ADDR_WIDTH
  - pointer-width constant (ADDR_WIDTH+1)
  - FWFT mode encodings (MODE_STD=0, MODE_FWFT=1)
- One natural sub-module: fifo_sync_mem.
  - DEPTH x DATA_WIDTH array, synchronous write, asynchronous read port.
  - The top holds pointers, flags, error logic and the FWFT/registered output mux.

Test Plan:
- Reset, then 8 writes of 0x10..0x17 with ren=0 -> wfull=1 after 8th edge; count=8; walmost_full=1 from count=6; a 9th write of 0xFF is rejected and sets overflow=1.
- FWFT=0, FIFO holding 0x10..0x17, ren=1 for 8 cycles -> rdata = 0x10..0x17, each one cycle after its read edge; rempty=1 after last; a 9th ren sets underflow=1 and rdata holds 0x17.
- FWFT=1, single write of 0xA5 into an empty FIFO -> rempty=0 and rdata=0xA5 the next cycle, before any ren; ren pops it and rempty=1.
- Simultaneous wen & ren at count=3 for 20 cycles, data incrementing -> count stays 3, read order matches write order across pointer wrap, no error flags.
- wen & ren when empty -> write accepted (count=1), underflow=1; then clr_err together with a further ren on empty -> underflow remains 1 (set wins); clr_err alone clears it.
- Assert rst mid-stream at count=5 -> all outputs return to reset values asynchronously; following write/read of 0x3C behaves as from empty.
